// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl
// Sequencer in front of a 16x32 register file that has one registered read
// stage and cannot read and write in the same cycle. Operand-read requests
// and writeback requests are arbitrated here; writebacks are buffered in a
// small FIFO and drained whenever the file is not being read.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   req_*                 operand read request (valid/ready, rs1/rs2 indices)
//   wb_*                  writeback request (valid/ready, rd index, data)
//   op_*                  operand pair to execute (valid/ready, a/b)
//   rf_rd_port1/2         register file read selects
//   rf_wr_reg/data, rf_we register file write select, data, enable
//   rf_out1/2             register file registered read data
//   err_idx               sticky flag: an out-of-range index was seen
module rf_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] rf_rd_port1,
  output logic [ADDR_W-1:0] rf_rd_port2,
  output logic [ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic              err_idx
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(WB_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(WB_DEPTH);
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WB,
    RD_ISSUE,
    RD_CAPTURE,
    OP_HOLD
  } state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_X);
  endfunction

  state_t              state_q, state_d;
  logic                init_q;
  logic [ADDR_W-1:0]   rs1_q, rs1_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;

  // Writeback FIFO storage; contents need no reset, the count qualifies them.
  logic [ADDR_W-1:0]   wb_rd_mem   [WB_DEPTH];
  logic [DATA_W-1:0]   wb_data_mem [WB_DEPTH];

  logic                wb_empty, wb_full, push, pop, head_ok;
  logic [ADDR_W-1:0]   head_rd;
  logic [DATA_W-1:0]   head_data;

  // ---------------------------------------------------------------------
  // Writeback buffer and drain
  // ---------------------------------------------------------------------
  always_comb begin
    wb_empty  = (wb_cnt_q == '0);
    wb_full   = (wb_cnt_q == CNT_FULL);
    // A full buffer refuses even if it drains this cycle.
    wb_ready  = !wb_full;
    push      = wb_valid && !wb_full;
    // The read-issue cycle owns the file; every other cycle may drain.
    pop       = !wb_empty && (state_q != RD_ISSUE);
    head_rd   = wb_rd_mem[rd_ptr_q];
    head_data = wb_data_mem[rd_ptr_q];
    head_ok   = in_range(head_rd);

    rf_we      = pop && head_ok;
    rf_wr_reg  = pop ? head_rd   : wr_reg_q;
    rf_wr_data = pop ? head_data : wr_data_q;
    wr_reg_d   = rf_wr_reg;
    wr_data_d  = rf_wr_data;

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    wb_cnt_d = wb_cnt_q;
    if (push && !pop)      wb_cnt_d = wb_cnt_q + 1'b1;
    else if (!push && pop) wb_cnt_d = wb_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_rd_mem[wr_ptr_q]   <= wb_rd;
      wb_data_mem[wr_ptr_q] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read sequencing FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    err_d     = err_q;
    req_ready = 1'b0;
    op_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        // init_q keeps the request port closed until the first edge after
        // reset release.
        req_ready = init_q;
        if (req_valid && init_q) begin
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          // A write accepted alongside the request must land before the read.
          state_d = (wb_empty && !push) ? RD_ISSUE : WAIT_WB;
        end
      end
      WAIT_WB: begin
        // Also require no new write this cycle, otherwise it would still be
        // buffered when the file is read.
        if (wb_empty && !push) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // rf_out reflects the selects of the issue cycle; the file holds its
        // outputs if a drain writes this cycle.
        op_a_d = in_range(rs1_q) ? rf_out1 : '0;
        op_b_d = in_range(rs2_q) ? rf_out2 : '0;
        if (!in_range(rs1_q) || !in_range(rs2_q)) err_d = 1'b1;
        state_d = OP_HOLD;
      end
      OP_HOLD: begin
        op_valid = 1'b1;
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Out-of-range writebacks are discarded at drain time.
    if (pop && !head_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      err_q     <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      wb_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      init_q    <= 1'b1;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      err_q     <= err_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      wb_cnt_q  <= wb_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign rf_rd_port1 = rs1_q;
  assign rf_rd_port2 = rs2_q;
  assign err_idx     = err_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl
// Directed bench for rf_access_ctrl with a behavioural 16x32 register file.
// Expected operand pairs and expected register-file writes are queued when
// stimulus is issued; two monitors pop and compare when the DUT presents an
// operand handshake or asserts rf_we.
module tb_rf_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  rf_rd_port1, rf_rd_port2, rf_wr_reg;
  logic [31:0] rf_wr_data;
  logic        rf_we;
  logic [31:0] rf_out1, rf_out2;
  logic        err_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] oq[$];   // {op_a, op_b}
  logic [36:0] wq[$];   // {rd, data}

  logic [31:0] rf_mem [16];

  rf_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .rf_rd_port1(rf_rd_port1), .rf_rd_port2(rf_rd_port2),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .rf_we(rf_we),
    .rf_out1(rf_out1), .rf_out2(rf_out2),
    .err_idx(err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: registered read unless writing this cycle.
  // Out-of-range read selects return a marker the DUT must zero.
  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'd0;
    rf_out1 = 32'd0;
    rf_out2 = 32'd0;
  end

  always @(posedge clk) begin
    if (rf_we) begin
      if (rf_wr_reg < 5'd16) rf_mem[rf_wr_reg[3:0]] <= rf_wr_data;
    end else begin
      rf_out1 <= (rf_rd_port1 < 5'd16) ? rf_mem[rf_rd_port1[3:0]] : 32'hBAD0BAD0;
      rf_out2 <= (rf_rd_port2 < 5'd16) ? rf_mem[rf_rd_port2[3:0]] : 32'hBAD0BAD0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand monitor
  always @(negedge clk) begin
    if (reset && op_valid && op_ready) begin
      if (oq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL op_unexpected: got a=0x%08h b=0x%08h expected no operand", op_a, op_b);
      end else begin
        logic [63:0] e;
        e = oq.pop_front();
        $display("op  : a=0x%08h b=0x%08h (exp a=0x%08h b=0x%08h)", op_a, op_b, e[63:32], e[31:0]);
        check("op_a", op_a, e[63:32]);
        check("op_b", op_b, e[31:0]);
      end
    end
  end

  // Register-file write monitor
  always @(negedge clk) begin
    if (reset && rf_we) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rf_write_unexpected: got r%0d=0x%08h expected no write", rf_wr_reg, rf_wr_data);
      end else begin
        logic [36:0] e;
        e = wq.pop_front();
        $display("rfw : r%0d=0x%08h (exp r%0d=0x%08h)", rf_wr_reg, rf_wr_data, e[36:32], e[31:0]);
        check("rf_wr_reg", 32'(rf_wr_reg), 32'(e[36:32]));
        check("rf_wr_data", rf_wr_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_ready();
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic rd_req(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] ea, input logic [31:0] eb, input bit track);
    wait_req_ready();
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    if (track) oq.push_back({ea, eb});
    $display("req : rs1=%0d rs2=%0d", rs1, rs2);
    tick();
    req_valid = 1'b0;
  endtask

  // Leaves wb_valid asserted so calls can be chained back to back.
  task automatic wb_drive(input logic [4:0] rd, input logic [31:0] data, input bit lands);
    int n = 0;
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    while (!wb_ready && n < 50) begin tick(); n++; end
    check("wb_ready_wait", 32'(wb_ready), 32'd1);
    if (lands) wq.push_back({rd, data});
    $display("wb  : r%0d=0x%08h", rd, data);
    tick();
  endtask

  task automatic wait_op(output int n);
    n = 0;
    while (!op_valid && n < 50) begin tick(); n++; end
    check("op_valid_wait", 32'(op_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    wb_valid = 1'b0;  wb_rd = '0;   wb_data = '0;
    op_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    reset = 1'b1;
    #1;
    check("req_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    check("req_ready_after_edge", 32'(req_ready), 32'd1);

    // Basic write then read, with latency
    wb_drive(5'd3, 32'hDEADBEEF, 1'b1);
    wb_valid = 1'b0;
    repeat (3) tick();
    rd_req(5'd3, 5'd0, 32'hDEADBEEF, 32'd0, 1'b1);
    wait_op(n);
    check("latency_empty_buf", 32'(n), 32'd2);
    tick();

    // RAW: writeback and request accepted in the same cycle
    wait_req_ready();
    check("raw_wb_ready", 32'(wb_ready), 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd3;
    wq.push_back({5'd5, 32'h12345678});
    oq.push_back({32'h12345678, 32'hDEADBEEF});
    $display("req : rs1=5 rs2=3 with wb r5=0x12345678 same cycle");
    tick();
    wb_valid = 1'b0; req_valid = 1'b0;
    wait_op(n);
    check("latency_raw_wait_wb", 32'(n), 32'd4);
    tick();

    // Back-to-back writebacks while a read is in flight
    rd_req(5'd5, 5'd3, 32'h12345678, 32'hDEADBEEF, 1'b1);
    wb_drive(5'd7, 32'hAAAA0007, 1'b1);
    wb_drive(5'd8, 32'hBBBB0008, 1'b1);
    wb_drive(5'd9, 32'hCCCC0009, 1'b1);
    wb_valid = 1'b0;
    repeat (3) tick();
    rd_req(5'd7, 5'd8, 32'hAAAA0007, 32'hBBBB0008, 1'b1);
    rd_req(5'd9, 5'd7, 32'hCCCC0009, 32'hAAAA0007, 1'b1);

    // Out-of-range indices
    wait_req_ready();
    check("err_before_oor", 32'(err_idx), 32'd0);
    rd_req(5'd3, 5'd20, 32'hDEADBEEF, 32'd0, 1'b1);
    wait_op(n);
    tick();
    check("err_after_oor_read", 32'(err_idx), 32'd1);
    wb_drive(5'd17, 32'h00000055, 1'b0);
    wb_valid = 1'b0;
    repeat (3) tick();
    check("err_sticky", 32'(err_idx), 32'd1);

    // Back-pressure on the operand port with a write draining underneath
    op_ready = 1'b0;
    rd_req(5'd7, 5'd9, 32'hAAAA0007, 32'hCCCC0009, 1'b1);
    wait_op(n);
    wb_drive(5'd10, 32'h00001010, 1'b1);
    wb_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_op_valid", 32'(op_valid), 32'd1);
      check("hold_op_a", op_a, 32'hAAAA0007);
      check("hold_op_b", op_b, 32'hCCCC0009);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    check("hold_writes_drained", 32'(wq.size()), 32'd0);
    op_ready = 1'b1;
    tick();
    rd_req(5'd10, 5'd9, 32'h00001010, 32'hCCCC0009, 1'b1);

    // Reset asserted during RD_CAPTURE with one buffered write
    rd_req(5'd3, 5'd0, 32'd0, 32'd0, 1'b0);
    wb_drive(5'd11, 32'h0000BAD1, 1'b0);
    wb_valid = 1'b0;
    check("capture_drain_active", 32'(rf_we), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midreset_rf_we", 32'(rf_we), 32'd0);
    check("midreset_op_valid", 32'(op_valid), 32'd0);
    check("midreset_wb_ready", 32'(wb_ready), 32'd1);
    check("midreset_req_ready", 32'(req_ready), 32'd0);
    check("midreset_err_idx", 32'(err_idx), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    rd_req(5'd11, 5'd3, 32'd0, 32'hDEADBEEF, 1'b1);

    n = 0;
    while (oq.size() != 0 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    check("op_queue_empty", 32'(oq.size()), 32'd0);
    check("wr_queue_empty", 32'(wq.size()), 32'd0);
    check("err_after_reset", 32'(err_idx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
